// File: rtl/tcdm_bank_ctrl.sv
// tcdm_bank_ctrl: per-bank TCDM slave front end driving one SRAM cut,
// with an idle-driven standby FSM.
// Optional build macro TCDM_BANK_CTRL_RDATA_REG_EN registers bank_q_i before
// tcdm_r_rdata_o, which gives two-cycle read latency.
module tcdm_bank_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BE_WIDTH    = DATA_WIDTH/8,
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  sleep_en_i,
  input  logic                  tcdm_req_i,
  input  logic [ADDR_WIDTH-1:0] tcdm_add_i,
  input  logic                  tcdm_wen_i,
  input  logic [BE_WIDTH-1:0]   tcdm_be_i,
  input  logic [DATA_WIDTH-1:0] tcdm_wdata_i,
  output logic                  tcdm_gnt_o,
  output logic                  tcdm_r_valid_o,
  output logic [DATA_WIDTH-1:0] tcdm_r_rdata_o,
  output logic                  bank_initn_o,
  output logic                  bank_stdby_o,
  output logic                  bank_csn_o,
  output logic                  bank_wen_o,
  output logic [DATA_WIDTH-1:0] bank_wmn_o,
  output logic [ADDR_WIDTH-1:0] bank_a_o,
  output logic [DATA_WIDTH-1:0] bank_d_o,
  input  logic [DATA_WIDTH-1:0] bank_q_i,
  output logic                  standby_o
);

  localparam int unsigned IDLE_W = 8;
  localparam int unsigned WAKE_W = 4;

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_STANDBY = 2'd1,
    ST_WAKE    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [WAKE_W-1:0]   wake_cnt_q, wake_cnt_d;
  logic                accept;
  logic                resp_pending;
  logic                idle;
  logic                rvalid_q;

  // Grant only while the cut is fully awake; a transaction is req & gnt.
  assign tcdm_gnt_o = (state_q == ST_ACTIVE) & tcdm_req_i;
  assign accept     = tcdm_req_i & tcdm_gnt_o;

  // Bank strobes are a direct translation of the accepted request.
  assign bank_csn_o = ~accept;
  assign bank_wen_o = tcdm_wen_i;
  assign bank_a_o   = tcdm_add_i;
  assign bank_d_o   = tcdm_wdata_i;

  // Bit write mask: low only for bits of enabled bytes on an accepted write.
  for (genvar i = 0; i < int'(DATA_WIDTH); i++) begin : g_wmn
    assign bank_wmn_o[i] = ~(accept & ~tcdm_wen_i & tcdm_be_i[i/8]);
  end

`ifdef TCDM_BANK_CTRL_RDATA_REG_EN
  logic                  v1_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Two-stage response pipe; Q is captured the cycle after the access.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      v1_q     <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      v1_q     <= accept;
      rvalid_q <= v1_q;
      if (v1_q) rdata_q <= bank_q_i;
    end
  end

  assign resp_pending   = accept | v1_q;
  assign tcdm_r_rdata_o = rdata_q;
`else
  // Response one cycle after accept; Q is passed straight through.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) rvalid_q <= 1'b0;
    else       rvalid_q <= accept;
  end

  assign resp_pending   = accept;
  assign tcdm_r_rdata_o = rvalid_q ? bank_q_i : '0;
`endif

  assign tcdm_r_valid_o = rvalid_q;

  // Idle means no request and nothing still in flight towards the requester.
  assign idle = ~tcdm_req_i & ~resp_pending;

  // Standby FSM next-state and counter logic.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    case (state_q)
      ST_ACTIVE: begin
        wake_cnt_d = '0;
        if (tcdm_req_i || !sleep_en_i) begin
          idle_cnt_d = '0;
        end else if (idle && (idle_cnt_q != IDLE_W'(IDLE_CYCLES))) begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
        if (sleep_en_i && idle && (idle_cnt_q == IDLE_W'(IDLE_CYCLES - 1))) begin
          state_d    = ST_STANDBY;
          idle_cnt_d = '0;
        end
      end
      ST_STANDBY: begin
        idle_cnt_d = '0;
        wake_cnt_d = '0;
        if (tcdm_req_i || !sleep_en_i) state_d = ST_WAKE;
      end
      ST_WAKE: begin
        idle_cnt_d = '0;
        if (wake_cnt_q == WAKE_W'(WAKE_CYCLES - 1)) begin
          state_d    = ST_ACTIVE;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + WAKE_W'(1);
        end
      end
      default: begin
        state_d    = ST_ACTIVE;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
      end
    endcase
  end

  // State, counters and registered bank control outputs.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= ST_ACTIVE;
      idle_cnt_q   <= '0;
      wake_cnt_q   <= '0;
      bank_stdby_o <= 1'b0;
      standby_o    <= 1'b0;
      bank_initn_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      wake_cnt_q   <= wake_cnt_d;
      bank_stdby_o <= (state_d == ST_STANDBY);
      standby_o    <= (state_d == ST_STANDBY);
      bank_initn_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tcdm_bank_ctrl.sv
// Directed bench for tcdm_bank_ctrl with a behavioural 1024x32 bank model.
module tb_tcdm_bank_ctrl;

`ifdef TCDM_BANK_CTRL_RDATA_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        sleep_en_i;
  logic        tcdm_req_i;
  logic [9:0]  tcdm_add_i;
  logic        tcdm_wen_i;
  logic [3:0]  tcdm_be_i;
  logic [31:0] tcdm_wdata_i;
  logic        tcdm_gnt_o;
  logic        tcdm_r_valid_o;
  logic [31:0] tcdm_r_rdata_o;
  logic        bank_initn_o;
  logic        bank_stdby_o;
  logic        bank_csn_o;
  logic        bank_wen_o;
  logic [31:0] bank_wmn_o;
  logic [9:0]  bank_a_o;
  logic [31:0] bank_d_o;
  logic [31:0] bank_q_i = 32'h0;
  logic        standby_o;

  logic [31:0] mem [1024] = '{default: 32'h0};

  int checks = 0;
  int passed = 0;

  tcdm_bank_ctrl dut (
    .CLK            (CLK),
    .RSTN           (RSTN),
    .sleep_en_i     (sleep_en_i),
    .tcdm_req_i     (tcdm_req_i),
    .tcdm_add_i     (tcdm_add_i),
    .tcdm_wen_i     (tcdm_wen_i),
    .tcdm_be_i      (tcdm_be_i),
    .tcdm_wdata_i   (tcdm_wdata_i),
    .tcdm_gnt_o     (tcdm_gnt_o),
    .tcdm_r_valid_o (tcdm_r_valid_o),
    .tcdm_r_rdata_o (tcdm_r_rdata_o),
    .bank_initn_o   (bank_initn_o),
    .bank_stdby_o   (bank_stdby_o),
    .bank_csn_o     (bank_csn_o),
    .bank_wen_o     (bank_wen_o),
    .bank_wmn_o     (bank_wmn_o),
    .bank_a_o       (bank_a_o),
    .bank_d_o       (bank_d_o),
    .bank_q_i       (bank_q_i),
    .standby_o      (standby_o)
  );

  always #5 CLK = ~CLK;

  // SRAM cut model: bit-masked write, registered read.
  always @(posedge CLK) begin
    if (!bank_csn_o) begin
      if (!bank_wen_o) mem[bank_a_o] <= (mem[bank_a_o] & bank_wmn_o) | (bank_d_o & ~bank_wmn_o);
      else             bank_q_i <= mem[bank_a_o];
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RSTN = 1'b0; sleep_en_i = 1'b0; tcdm_req_i = 1'b0; tcdm_add_i = '0;
    tcdm_wen_i = 1'b1; tcdm_be_i = '0; tcdm_wdata_i = '0;
    cyc(); cyc(); #1;
    checks++; if (bank_initn_o !== 1'b0) $display("FAIL rst_initn: got %0b want 0", bank_initn_o); else passed++;
    checks++; if (bank_stdby_o !== 1'b0 || standby_o !== 1'b0) $display("FAIL rst_stdby: got %0b/%0b want 0/0", bank_stdby_o, standby_o); else passed++;
    checks++; if (tcdm_r_valid_o !== 1'b0) $display("FAIL rst_rvalid: got %0b want 0", tcdm_r_valid_o); else passed++;
    checks++; if (tcdm_r_rdata_o !== 32'h0) $display("FAIL rst_rdata: got %h want 0", tcdm_r_rdata_o); else passed++;
    checks++; if (bank_csn_o !== 1'b1 || bank_wmn_o !== 32'hFFFFFFFF) $display("FAIL rst_strobes: csn %0b wmn %h want 1 ffffffff", bank_csn_o, bank_wmn_o); else passed++;
    RSTN = 1'b1;
    #1;
    checks++; if (bank_initn_o !== 1'b0) $display("FAIL initn_pre_edge: got %0b want 0", bank_initn_o); else passed++;
    cyc();
    checks++; if (bank_initn_o !== 1'b1) $display("FAIL initn_post_edge: got %0b want 1", bank_initn_o); else passed++;
  endtask

  task automatic test_write();
    cyc();
    tcdm_req_i = 1'b1; tcdm_wen_i = 1'b0; tcdm_add_i = 10'h005; tcdm_be_i = 4'b0101; tcdm_wdata_i = 32'hAABBCCDD;
    #1;
    checks++; if (tcdm_gnt_o !== 1'b1) $display("FAIL wr_gnt: got %0b want 1", tcdm_gnt_o); else passed++;
    checks++; if (bank_csn_o !== 1'b0 || bank_wen_o !== 1'b0) $display("FAIL wr_csn_wen: got %0b/%0b want 0/0", bank_csn_o, bank_wen_o); else passed++;
    checks++; if (bank_wmn_o !== 32'hFF00FF00) $display("FAIL wr_wmn: got %h want ff00ff00", bank_wmn_o); else passed++;
    checks++; if (bank_a_o !== 10'h005 || bank_d_o !== 32'hAABBCCDD) $display("FAIL wr_a_d: got %h/%h want 005/aabbccdd", bank_a_o, bank_d_o); else passed++;
    for (int k = 1; k <= LAT; k++) begin
      cyc();
      tcdm_req_i = 1'b0; tcdm_wen_i = 1'b1;
      #1;
      checks++; if (tcdm_r_valid_o !== (k == LAT)) $display("FAIL wr_rvalid_c%0d: got %0b want %0b", k, tcdm_r_valid_o, (k == LAT)); else passed++;
    end
    checks++; if (bank_wmn_o !== 32'hFFFFFFFF || bank_csn_o !== 1'b1) $display("FAIL idle_strobes: wmn %h csn %0b want ffffffff 1", bank_wmn_o, bank_csn_o); else passed++;
    cyc();
    checks++; if (tcdm_r_valid_o !== 1'b0) $display("FAIL wr_rvalid_single: got %0b want 0", tcdm_r_valid_o); else passed++;
  endtask

  task automatic test_read();
    cyc();
    tcdm_req_i = 1'b1; tcdm_wen_i = 1'b1; tcdm_add_i = 10'h005;
    #1;
    checks++; if (tcdm_gnt_o !== 1'b1 || bank_csn_o !== 1'b0 || bank_wmn_o !== 32'hFFFFFFFF) $display("FAIL rd_strobes: gnt %0b csn %0b wmn %h want 1 0 ffffffff", tcdm_gnt_o, bank_csn_o, bank_wmn_o); else passed++;
    for (int k = 1; k <= LAT; k++) begin
      cyc();
      tcdm_req_i = 1'b0;
      #1;
      checks++; if (tcdm_r_valid_o !== (k == LAT)) $display("FAIL rd_rvalid_c%0d: got %0b want %0b", k, tcdm_r_valid_o, (k == LAT)); else passed++;
    end
    checks++; if (tcdm_r_rdata_o !== 32'h00BB00DD) $display("FAIL rd_rdata: got %h want 00bb00dd", tcdm_r_rdata_o); else passed++;
  endtask

  task automatic test_idle_entry();
    // sleep disabled: no standby however long the bank idles
    repeat (25) cyc();
    checks++; if (bank_stdby_o !== 1'b0 || standby_o !== 1'b0) $display("FAIL nosleep_stdby: got %0b/%0b want 0/0", bank_stdby_o, standby_o); else passed++;
    cyc();
    sleep_en_i = 1'b1; tcdm_req_i = 1'b1; tcdm_wen_i = 1'b1; tcdm_add_i = 10'h005;
    for (int k = 1; k <= LAT; k++) begin
      cyc();
      tcdm_req_i = 1'b0;
    end
    #1;
    checks++; if (tcdm_r_valid_o !== 1'b1) $display("FAIL idle_resp: got %0b want 1", tcdm_r_valid_o); else passed++;
    repeat (15) cyc();
    checks++; if (bank_stdby_o !== 1'b0) $display("FAIL stdby_early: got %0b want 0", bank_stdby_o); else passed++;
    cyc();
    checks++; if (bank_stdby_o !== 1'b1 || standby_o !== 1'b1) $display("FAIL stdby_entry: got %0b/%0b want 1/1", bank_stdby_o, standby_o); else passed++;
    repeat (5) cyc();
    checks++; if (bank_stdby_o !== 1'b1) $display("FAIL stdby_hold: got %0b want 1", bank_stdby_o); else passed++;
  endtask

  task automatic test_wake();
    int pulses = 0;
    cyc();
    tcdm_req_i = 1'b1; tcdm_wen_i = 1'b1; tcdm_add_i = 10'h005;
    #1;
    if (!bank_csn_o) pulses++;
    checks++; if (tcdm_gnt_o !== 1'b0 || bank_stdby_o !== 1'b1) $display("FAIL wake_c0: gnt %0b stdby %0b want 0 1", tcdm_gnt_o, bank_stdby_o); else passed++;
    cyc();
    if (!bank_csn_o) pulses++;
    checks++; if (bank_stdby_o !== 1'b0 || standby_o !== 1'b0 || tcdm_gnt_o !== 1'b0) $display("FAIL wake_c1: stdby %0b st %0b gnt %0b want 0 0 0", bank_stdby_o, standby_o, tcdm_gnt_o); else passed++;
    cyc();
    if (!bank_csn_o) pulses++;
    checks++; if (tcdm_gnt_o !== 1'b0) $display("FAIL wake_c2: gnt %0b want 0", tcdm_gnt_o); else passed++;
    cyc();
    if (!bank_csn_o) pulses++;
    checks++; if (tcdm_gnt_o !== 1'b1 || bank_csn_o !== 1'b0) $display("FAIL wake_c3: gnt %0b csn %0b want 1 0", tcdm_gnt_o, bank_csn_o); else passed++;
    for (int k = 1; k <= LAT; k++) begin
      cyc();
      tcdm_req_i = 1'b0;
      #1;
      if (!bank_csn_o) pulses++;
    end
    checks++; if (tcdm_r_valid_o !== 1'b1 || tcdm_r_rdata_o !== 32'h00BB00DD) $display("FAIL wake_resp: rvalid %0b rdata %h want 1 00bb00dd", tcdm_r_valid_o, tcdm_r_rdata_o); else passed++;
    checks++; if (pulses !== 1) $display("FAIL wake_csn_pulses: got %0d want 1", pulses); else passed++;
  endtask

  task automatic test_sleep_exit();
    repeat (20) cyc();
    checks++; if (standby_o !== 1'b1) $display("FAIL reenter_standby: got %0b want 1", standby_o); else passed++;
    cyc();
    sleep_en_i = 1'b0;
    #1;
    checks++; if (bank_stdby_o !== 1'b1) $display("FAIL sleepoff_c0: got %0b want 1", bank_stdby_o); else passed++;
    cyc();
    checks++; if (bank_stdby_o !== 1'b0) $display("FAIL sleepoff_c1: got %0b want 0", bank_stdby_o); else passed++;
    cyc();
    tcdm_req_i = 1'b1; tcdm_wen_i = 1'b1; tcdm_add_i = 10'h005;
    #1;
    checks++; if (tcdm_gnt_o !== 1'b0) $display("FAIL sleepoff_c2_gnt: got %0b want 0", tcdm_gnt_o); else passed++;
    cyc();
    checks++; if (tcdm_gnt_o !== 1'b1) $display("FAIL sleepoff_c3_gnt: got %0b want 1", tcdm_gnt_o); else passed++;
    for (int k = 1; k <= LAT; k++) begin
      cyc();
      tcdm_req_i = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      cyc();
      tcdm_req_i = 1'b1; tcdm_wen_i = 1'b0; tcdm_be_i = 4'hF; tcdm_add_i = 10'(i); tcdm_wdata_i = 32'h1000 + 32'(i);
      #1;
      checks++; if (tcdm_gnt_o !== 1'b1) $display("FAIL b2b_wr_gnt%0d: got %0b want 1", i, tcdm_gnt_o); else passed++;
    end
    for (int i = 0; i < 8 + LAT; i++) begin
      cyc();
      tcdm_req_i = (i < 8); tcdm_wen_i = 1'b1; tcdm_add_i = 10'(i);
      #1;
      if (i < 8) begin
        checks++; if (tcdm_gnt_o !== 1'b1) $display("FAIL b2b_rd_gnt%0d: got %0b want 1", i, tcdm_gnt_o); else passed++;
      end
      if (i >= LAT) begin
        checks++; if (tcdm_r_valid_o !== 1'b1 || tcdm_r_rdata_o !== 32'h1000 + 32'(i - LAT)) $display("FAIL b2b_rd_data%0d: rvalid %0b rdata %h want 1 %h", i - LAT, tcdm_r_valid_o, tcdm_r_rdata_o, 32'h1000 + 32'(i - LAT)); else passed++;
      end
    end
    cyc();
    checks++; if (tcdm_r_valid_o !== 1'b0) $display("FAIL b2b_tail: got %0b want 0", tcdm_r_valid_o); else passed++;
  endtask

  task automatic test_async_reset();
    cyc();
    tcdm_req_i = 1'b1; tcdm_wen_i = 1'b1; tcdm_add_i = 10'h002;
    #2;
    RSTN = 1'b0;
    #1;
    checks++; if (tcdm_r_valid_o !== 1'b0 || bank_stdby_o !== 1'b0 || bank_initn_o !== 1'b0) $display("FAIL arst_now: rvalid %0b stdby %0b initn %0b want 0 0 0", tcdm_r_valid_o, bank_stdby_o, bank_initn_o); else passed++;
    tcdm_req_i = 1'b0;
    cyc();
    checks++; if (tcdm_r_valid_o !== 1'b0) $display("FAIL arst_dropped: got %0b want 0", tcdm_r_valid_o); else passed++;
    cyc();
    RSTN = 1'b1;
    #1;
    checks++; if (bank_initn_o !== 1'b0) $display("FAIL arst_initn_pre: got %0b want 0", bank_initn_o); else passed++;
    cyc();
    tcdm_req_i = 1'b1;
    #1;
    checks++; if (bank_initn_o !== 1'b1 || tcdm_gnt_o !== 1'b1) $display("FAIL arst_recover: initn %0b gnt %0b want 1 1", bank_initn_o, tcdm_gnt_o); else passed++;
    cyc();
    tcdm_req_i = 1'b0;
    repeat (LAT) cyc();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_idle_entry();
    test_wake();
    test_sleep_exit();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
